mem_io_responder: RTL and testbench

//  Memory-side responder for the single-cycle MIPS core's data port on the board build.

---
 rtl/mem_io_responder.sv | 158 +++++++++++++++
 tb/tb_mem_io_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Data-port responder for the single-cycle MIPS core: word RAM plus memory-mapped
// switches, debounced buttons, LEDs and a scanned 8-digit seven-segment display.
module mem_io_responder #(
    parameter int RAM_AW    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] switch,
    input  logic [3:0]  btn,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  a2g,
    output logic        dp
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    localparam logic [29:0] SW_WADDR  = 30'h3FFF_FFFC;
    localparam logic [29:0] BTN_WADDR = 30'h3FFF_FFFD;
    localparam logic [29:0] LED_WADDR = 30'h3FFF_FFFE;
    localparam logic [29:0] SEG_WADDR = 30'h3FFF_FFFF;

    logic [29:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_ram;
    logic              is_sw;
    logic              is_btn;
    logic              is_led;
    logic              is_seg;

    logic [31:0] ram [2**RAM_AW];
    logic [31:0] seg_reg;

    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit;

    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      btn_db;
    logic [DB_W-1:0] db_cnt [4];

    // Byte offset bits are dropped by the shift so only word addresses are decoded.
    assign word_addr = 30'(addr >> 2);
    assign ram_idx   = word_addr[RAM_AW-1:0];
    assign is_ram    = (word_addr[29:RAM_AW] == '0);
    assign is_sw     = (word_addr == SW_WADDR);
    assign is_btn    = (word_addr == BTN_WADDR);
    assign is_led    = (word_addr == LED_WADDR);
    assign is_seg    = (word_addr == SEG_WADDR);

    assign dp = 1'b1;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (memwrite && is_ram)
            ram[ram_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led     <= '0;
            seg_reg <= '0;
        end else if (memwrite) begin
            if (is_led)
                led <= writedata[15:0];
            if (is_seg)
                seg_reg <= writedata;
        end
    end

    always_comb begin
        readdata = '0;
        if (is_ram)
            readdata = ram[ram_idx];
        else if (is_sw)
            readdata = {16'b0, switch};
        else if (is_btn)
            readdata = {28'b0, btn_db};
        else if (is_led)
            readdata = {16'b0, led};
        else if (is_seg)
            readdata = seg_reg;
    end

    // an/a2g are both registered from the same digit and seg_reg sample, so they switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
            an       <= 8'hFE;
            a2g      <= 7'b1000000;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                digit    <= digit + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(8'b1 << digit);
            a2g <= hex7(seg_reg[{digit, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            btn_db <= '0;
            for (int unsigned i = 0; i < 4; i++)
                db_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a table of bus accesses plus hand-written
// sequences for display scanning, button debounce and asynchronous reset.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] switch;
    logic [3:0]  btn;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  a2g;
    logic        dp;

    int tests  = 0;
    int failed = 0;

    mem_io_responder #(
        .RAM_AW(6),
        .SCAN_DIV(4),
        .DB_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .addr(addr),
        .writedata(writedata),
        .readdata(readdata),
        .switch(switch),
        .btn(btn),
        .led(led),
        .an(an),
        .a2g(a2g),
        .dp(dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [15:0] led;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    function automatic logic [6:0] seg_expect(input int d);
        if (d == 0) return 7'b0110000;
        if (d == 1) return 7'b0001110;
        return 7'b1000000;
    endfunction

    initial begin
        int         prev_d;
        int         run_len;
        int         first_run;
        int         transitions;
        int         cur_d;
        logic [3:0] seen;
        logic       found;

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 16'h0000};
        vecs[1]  = '{1'b1, 32'h0000_00FC, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h0000};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 16'h0000};
        vecs[3]  = '{1'b0, 32'h0000_00FE, 32'h0,         32'hDEAD_BEEF, 16'h0000};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 32'h1111_1111, 16'h0000};
        vecs[5]  = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_A5A5, 32'h0000_A5A5, 16'hA5A5};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_8001, 16'hA5A5};
        vecs[7]  = '{1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_A5A5, 16'hA5A5};
        vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 16'hA5A5};
        vecs[9]  = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 16'hA5A5};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 16'hA5A5};
        vecs[11] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 16'hA5A5};
        vecs[12] = '{1'b1, 32'hFFFF_FFF4, 32'h0000_000F, 32'h0000_0000, 16'hA5A5};
        vecs[13] = '{1'b1, 32'hFFFF_FFFC, 32'h89AB_CDEF, 32'h89AB_CDEF, 16'hA5A5};
        vecs[14] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
        vecs[15] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         32'h0000_8001, 16'hA5A5};
        vecs[16] = '{1'b0, 32'hFFFF_FFFB, 32'h0,         32'h0000_A5A5, 16'hA5A5};

        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'hFFFF_FFF4;
        writedata = '0;
        switch    = 16'h8001;
        btn       = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_led", {16'b0, led}, 32'h0);
        check("reset_an", {24'b0, an}, 32'hFE);
        check("reset_a2g", {25'b0, a2g}, 32'h40);
        check("reset_dp", {31'b0, dp}, 32'h1);
        check("reset_btn_read", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            addr      = vecs[i].a;
            writedata = vecs[i].wd;
            memwrite  = vecs[i].we;
            @(posedge clk);
            #1;
            memwrite = 1'b0;
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].rd);
            check($sformatf("vec%0d_led", i), {16'b0, led}, {16'b0, vecs[i].led});
        end

        // Display scan with digits 0 and 1 programmed to "3" and "F".
        bus_write(32'hFFFF_FFFC, 32'h0000_00F3);
        repeat (2) @(posedge clk);
        prev_d      = -1;
        run_len     = 0;
        first_run   = 1;
        transitions = 0;
        for (int s = 0; s < 32; s++) begin
            @(posedge clk);
            #1;
            cur_d = -1;
            for (int d = 0; d < 8; d++)
                if (an == ~(8'b1 << d)) cur_d = d;
            tests++;
            if (cur_d < 0) begin
                failed++;
                $display("FAIL scan_an_onehot: got %h expected one-hot-low", an);
            end else begin
                check($sformatf("scan_a2g_s%0d", s), {25'b0, a2g}, {25'b0, seg_expect(cur_d)});
                if (prev_d >= 0 && cur_d != prev_d) begin
                    check($sformatf("scan_step_s%0d", s), cur_d, (prev_d + 1) % 8);
                    if (!first_run)
                        check($sformatf("scan_dwell_s%0d", s), run_len, 4);
                    first_run = 0;
                    transitions++;
                    run_len = 1;
                end else begin
                    run_len++;
                end
                prev_d = cur_d;
            end
        end
        check("scan_transitions", {31'b0, transitions >= 7}, 32'h1);

        // Debounce: a short pulse must be rejected.
        @(negedge clk);
        addr = 32'hFFFF_FFF4;
        btn  = 4'b0100;
        seen = '0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen |= readdata[3:0];
        end
        @(negedge clk);
        btn = 4'b0000;
        repeat (14) begin
            @(posedge clk);
            #1;
            seen |= readdata[3:0];
        end
        check("btn_bounce_rejected", {28'b0, seen}, 32'h0);

        // Debounce: stable press accepted exactly 2+DB_CYCLES edges later, same for release.
        @(negedge clk);
        btn = 4'b0100;
        repeat (9) @(posedge clk);
        #1;
        check("btn_press_early", readdata, 32'h0);
        @(posedge clk);
        #1;
        check("btn_press_accept", readdata, 32'h4);
        @(negedge clk);
        btn = 4'b0000;
        repeat (9) @(posedge clk);
        #1;
        check("btn_release_early", readdata, 32'h4);
        @(posedge clk);
        #1;
        check("btn_release_accept", readdata, 32'h0);

        // Asynchronous reset mid-scan with live LED, SEG and button state.
        bus_write(32'hFFFF_FFF8, 32'h0000_00FF);
        bus_write(32'hFFFF_FFFC, 32'h1234_5678);
        @(negedge clk);
        addr = 32'hFFFF_FFF4;
        btn  = 4'b0010;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_btn", readdata, 32'h2);
        check("pre_reset_led", {16'b0, led}, 32'h00FF);
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(posedge clk);
            #1;
            if (an == 8'hDF) found = 1'b1;
        end
        check("wait_digit5", {31'b0, found}, 32'h1);
        #2;
        reset = 1'b1;
        btn   = 4'b0000;
        #1;
        check("async_reset_led", {16'b0, led}, 32'h0);
        check("async_reset_an", {24'b0, an}, 32'hFE);
        check("async_reset_a2g", {25'b0, a2g}, 32'h40);
        check("async_reset_btn", readdata, 32'h0);
        addr = 32'hFFFF_FFFC;
        #1;
        check("async_reset_seg", readdata, 32'h0);
        addr = 32'h0000_0004;
        #1;
        check("ram_retained", readdata, 32'h1234_5678);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_digit0", {24'b0, an}, 32'hFE);
        @(posedge clk);
        #1;
        check("post_reset_digit1", {24'b0, an}, 32'hFD);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
